apb_mem_slave_p: RTL and testbench
==================================

# apb_mem_slave_p

Parametrised APB memory slave: word-organised register file behind an APB completer interface. Adds configurable wait states, byte-lane write strobes and an error response for out-of-range addresses. Sits on an APB bus segment behind the decoder, one PSEL per instance, and plugs in alongside the existing fixed 32x64 slaves.

## Interface
Parameters:
- DATA_WIDTH, 32: data bus width; legal values 8, 16, 32, 64.
- ADDR_WIDTH, 32: paddr width.
- DEPTH, 64: number of DATA_WIDTH words; 1..2^(ADDR_WIDTH-OFF).
- WAIT_STATES, 0: extra cycles PREADY is held low per transfer; 0..15.

Derived: NB = DATA_WIDTH/8; OFF = log2(NB).

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  synchronous, active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase marker.
- PWRITE  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  NB  byte-lane write enables; ignored on reads.
- PREADY  out  1  transfer complete, registered.
- PSLVERR  out  1  error response, valid only while PREADY=1.
- prdata  out  DATA_WIDTH  read data, valid while PREADY=1 on a read.

## Operation
- Word index = paddr[ADDR_WIDTH-1:OFF]; paddr[OFF-1:0] ignored, with no misalignment error. Out of range when index >= DEPTH, compared at full width.
- State machine IDLE, WAIT, RESP. Reset puts it in IDLE.
- IDLE: if PSEL & PENABLE:
  - WAIT_STATES = 0: execute the access, set PREADY<=1, go to RESP.
  - Otherwise: cnt<=WAIT_STATES, go to WAIT.
- WAIT:
  - If PSEL=0 or PENABLE=0 (abort): go to IDLE. No memory change, PREADY stays 0.
  - Else if cnt==1: execute the access, PREADY<=1, go to RESP.
  - Else: cnt<=cnt-1.
- RESP: PREADY<=0, PSLVERR<=0, go to IDLE unconditionally.
- Execute, in range:
  - Write: for each lane b with pstrb[b]=1, mem[index][8b+7:8b] <= pwdata[8b+7:8b]. Other lanes are kept. pstrb=0 is a legal no-op write.
  - Read: prdata <= mem[index].
  - PSLVERR<=0.
- Execute, out of range: no memory change. PSLVERR<=1. On a read, prdata<=0.
- prdata holds its last value outside read responses; it is not cleared after RESP.
- paddr, pwdata, pstrb and PWRITE are sampled on the execute edge. The APB master holds them stable through the access phase.
- Reset: every mem word, prdata, PREADY, PSLVERR and cnt go to 0; state goes to IDLE. Reset asserted mid-transfer (any state) overrides everything, and a pending write is discarded.

## Timing
- Cycle N is the first access-phase cycle (PSEL=PENABLE=1). PREADY is high in exactly cycle N+1+WAIT_STATES, for exactly one cycle.
- The transfer completes at the end of that cycle. Access phase length = WAIT_STATES+2 cycles.
- Write data is visible to a read whose access phase starts on or after the cycle following PREADY.
- Back-to-back transfers: the next setup cycle (PENABLE=0) falls while the FSM is in IDLE. No dead cycle beyond the APB setup phase.
- Throughput: one transfer per WAIT_STATES+3 cycles, counting the setup cycle.
- PSEL=1 with PENABLE=0 (setup phase) never starts a transfer.
- PSLVERR and PREADY assert and deassert on the same edges.

## Test plan
- Reset, DATA_WIDTH=32, WAIT_STATES=0: hold PRESETn=0 for 2 cycles, then read index 5 -> PREADY in N+1, prdata=0x00000000, PSLVERR=0; PREADY=0 in N+2.
- WAIT_STATES=3: write 0xDEADBEEF to paddr 0x10, pstrb=4'hF, then read 0x10 -> PREADY low for N..N+3 and high only in N+4 on both transfers; read prdata=0xDEADBEEF.
- Byte strobes: write 0x11223344 to 0x08 with pstrb=4'hF, then 0xAABBCCDD with pstrb=4'b0101 -> read 0x08 returns 0x11BB33DD.
- Out of range, DEPTH=64: write 0xFFFFFFFF to paddr 0x100 (index 64) -> PREADY and PSLVERR both high in the same cycle, and indices 0..63 are unchanged. Read 0x100 -> PSLVERR=1, prdata=0.
- Abort and reset, WAIT_STATES=4:
  - Drop PSEL in cycle N+2 of a write to 0x04 -> no PREADY pulse, and mem[1] is unchanged.
  - Assert PRESETn=0 during WAIT -> PREADY=0, PSLVERR=0, prdata=0 on the next edge, and a subsequent read of 0x04 returns 0.
- DATA_WIDTH=64: paddr 0x18 and 0x1F both map to index 3. Write 0x0123456789ABCDEF to 0x18, read 0x1F -> 0x0123456789ABCDEF.

Source files
------------

// File: rtl/apb_mem_slave_p.sv
// apb_mem_slave_p
// ---------------------------------------------------------------------------
// Word-organised register file behind an APB completer interface, with
// configurable wait states, byte-lane write strobes and an error response
// for word indices beyond DEPTH.
//
// Parameters
//   DATA_WIDTH   data bus width (8, 16, 32 or 64)
//   ADDR_WIDTH   paddr width
//   DEPTH        number of DATA_WIDTH words
//   WAIT_STATES  extra cycles PREADY is held low per transfer (0..15)
//
// Ports
//   PCLK      in   clock, all logic on the rising edge
//   PRESETn   in   synchronous active-low reset (clears memory as well)
//   PSEL      in   slave select
//   PENABLE   in   access phase marker
//   PWRITE    in   1 = write, 0 = read
//   paddr     in   byte address; the low log2(DATA_WIDTH/8) bits are ignored
//   pwdata    in   write data
//   pstrb     in   byte-lane write enables, ignored on reads
//   PREADY    out  registered one-cycle transfer-complete pulse
//   PSLVERR   out  error response, meaningful only while PREADY=1
//   prdata    out  read data, holds its last value outside read responses
// ---------------------------------------------------------------------------
module apb_mem_slave_p #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [DATA_WIDTH-1:0]   prdata
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = ADDR_WIDTH - OFF;
    localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so that DEPTH == 2^IW is still representable.
    localparam logic [IW:0] DEPTH_X  = (IW + 1)'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic                  pready_nxt;
    logic                  pslverr_nxt;
    logic                  exec;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0]         word_idx;
    logic [MW-1:0]         mem_idx;
    logic                  out_of_range;

    assign word_idx     = paddr[ADDR_WIDTH-1:OFF];
    assign mem_idx      = word_idx[MW-1:0];
    // Full-width compare: high address bits must not alias onto valid words.
    assign out_of_range = ({1'b0, word_idx} >= DEPTH_X);

    // Byte-offset bits inside a word carry no meaning; no misalignment error.
    generate
        if (OFF > 0) begin : g_low_bits
            logic unused_low_bits;
            assign unused_low_bits = ^paddr[OFF-1:0];
        end
    endgenerate

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and registered-output decode. "exec" marks the edge on
    // which the access takes effect; address/data/strobe are sampled there.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pready_nxt  = 1'b0;
        pslverr_nxt = 1'b0;
        exec        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (PSEL && PENABLE) begin
                    if (WAIT_STATES == 0) begin
                        exec        = 1'b1;
                        pready_nxt  = 1'b1;
                        pslverr_nxt = out_of_range;
                        state_nxt   = S_RESP;
                    end else begin
                        cnt_nxt   = CNT_INIT;
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL || !PENABLE) begin
                    // Master abandoned the transfer: no memory side effect.
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd1) begin
                    exec        = 1'b1;
                    pready_nxt  = 1'b1;
                    pslverr_nxt = out_of_range;
                    state_nxt   = S_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            cnt     <= 4'd0;
            prdata  <= '0;
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else begin
            PREADY  <= pready_nxt;
            PSLVERR <= pslverr_nxt;
            cnt     <= cnt_nxt;
            if (exec && PWRITE && !out_of_range) begin
                for (int b = 0; b < NB; b++) begin
                    if (pstrb[b]) begin
                        mem[mem_idx][8*b +: 8] <= pwdata[8*b +: 8];
                    end
                end
            end
            if (exec && !PWRITE) begin
                prdata <= out_of_range ? '0 : mem[mem_idx];
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Testbench for apb_mem_slave_p. Four instances with different
// width/wait-state configurations share one clock; each has its own reset.
//   u0: 32-bit, WAIT_STATES=0   u1: 32-bit, WAIT_STATES=3
//   u2: 32-bit, WAIT_STATES=4   u3: 64-bit, WAIT_STATES=2
module tb_apb_mem_slave_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn  [4];
    logic        psel  [4];
    logic        pen   [4];
    logic        pwr   [4];
    logic [31:0] addr  [4];
    logic [63:0] wdata [4];
    logic [7:0]  strb  [4];

    logic        rdy0, rdy1, rdy2, rdy3;
    logic        err0, err1, err2, err3;
    logic [31:0] rd0, rd1, rd2;
    logic [63:0] rd3;

    apb_mem_slave_p #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u0 (
        .PCLK(clk), .PRESETn(rstn[0]), .PSEL(psel[0]), .PENABLE(pen[0]), .PWRITE(pwr[0]),
        .paddr(addr[0]), .pwdata(wdata[0][31:0]), .pstrb(strb[0][3:0]),
        .PREADY(rdy0), .PSLVERR(err0), .prdata(rd0));

    apb_mem_slave_p #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u1 (
        .PCLK(clk), .PRESETn(rstn[1]), .PSEL(psel[1]), .PENABLE(pen[1]), .PWRITE(pwr[1]),
        .paddr(addr[1]), .pwdata(wdata[1][31:0]), .pstrb(strb[1][3:0]),
        .PREADY(rdy1), .PSLVERR(err1), .prdata(rd1));

    apb_mem_slave_p #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(4)) u2 (
        .PCLK(clk), .PRESETn(rstn[2]), .PSEL(psel[2]), .PENABLE(pen[2]), .PWRITE(pwr[2]),
        .paddr(addr[2]), .pwdata(wdata[2][31:0]), .pstrb(strb[2][3:0]),
        .PREADY(rdy2), .PSLVERR(err2), .prdata(rd2));

    apb_mem_slave_p #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(2)) u3 (
        .PCLK(clk), .PRESETn(rstn[3]), .PSEL(psel[3]), .PENABLE(pen[3]), .PWRITE(pwr[3]),
        .paddr(addr[3]), .pwdata(wdata[3]), .pstrb(strb[3]),
        .PREADY(rdy3), .PSLVERR(err3), .prdata(rd3));

    function automatic logic f_rdy(input int u);
        case (u)
            0: return rdy0;
            1: return rdy1;
            2: return rdy2;
            default: return rdy3;
        endcase
    endfunction

    function automatic logic f_err(input int u);
        case (u)
            0: return err0;
            1: return err1;
            2: return err2;
            default: return err3;
        endcase
    endfunction

    function automatic logic [63:0] f_rd(input int u);
        case (u)
            0: return {32'h0, rd0};
            1: return {32'h0, rd1};
            2: return {32'h0, rd2};
            default: return rd3;
        endcase
    endfunction

    function automatic int f_ws(input int u);
        case (u)
            0: return 0;
            1: return 3;
            2: return 4;
            default: return 2;
        endcase
    endfunction

    typedef struct {
        int          u;
        bit          wr;
        bit          err;
        logic [63:0] data;
        int          start;
    } exp_t;

    exp_t sbq [$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per PREADY pulse and checks response,
    // latency, and that the pulse lasts exactly one cycle.
    bit prev_rdy [4];
    always @(negedge clk) begin
        exp_t e;
        for (int u = 0; u < 4; u++) begin
            if (prev_rdy[u]) begin
                chk($sformatf("u%0d pready_drop", u), {62'h0, f_rdy(u), f_err(u)}, 64'h0);
            end
            if (f_rdy(u) === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL u%0d unexpected_pready: got PREADY=1, expected no transfer (cycle %0d)", u, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("u%0d instance", u), 64'(u), 64'(e.u));
                    chk($sformatf("u%0d latency", u), 64'(cyc - e.start), 64'(1 + f_ws(u)));
                    chk($sformatf("u%0d pslverr", u), {63'h0, f_err(u)}, {63'h0, e.err});
                    if (!e.wr) begin
                        chk($sformatf("u%0d prdata", u), f_rd(u), e.data);
                    end
                end
            end
            prev_rdy[u] = (f_rdy(u) === 1'b1);
        end
    end

    // One APB transfer; called #1 after a rising edge, returns #1 after the
    // completion edge with the bus idle so calls can run back to back.
    task automatic xfer(input int u, input bit wr, input logic [31:0] a, input logic [63:0] d,
                        input logic [7:0] s, input bit exp_err, input logic [63:0] exp_d,
                        input int setup_len);
        exp_t e;
        logic got;
        psel[u]  = 1'b1;
        pen[u]   = 1'b0;
        pwr[u]   = wr;
        addr[u]  = a;
        wdata[u] = d;
        strb[u]  = s;
        for (int i = 0; i < setup_len; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("u%0d setup_no_ready", u), {63'h0, f_rdy(u)}, 64'h0);
        end
        pen[u]  = 1'b1;
        e.u     = u;
        e.wr    = wr;
        e.err   = exp_err;
        e.data  = (u == 3) ? exp_d : {32'h0, exp_d[31:0]};
        e.start = cyc;
        sbq.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            got = f_rdy(u);
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL u%0d timeout: got no PREADY within 40 cycles, expected PREADY at N+%0d", u, 1 + f_ws(u));
            void'(sbq.pop_back());
        end
        @(posedge clk);
        #1;
        psel[u] = 1'b0;
        pen[u]  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] sweep_exp;
        for (int u = 0; u < 4; u++) begin
            rstn[u]  = 1'b0;
            psel[u]  = 1'b0;
            pen[u]   = 1'b0;
            pwr[u]   = 1'b0;
            addr[u]  = '0;
            wdata[u] = '0;
            strb[u]  = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 4; u++) rstn[u] = 1'b1;
        for (int u = 0; u < 4; u++) begin
            chk($sformatf("u%0d reset_state", u), {f_rd(u)[61:0], f_rdy(u), f_err(u)}, 64'h0);
        end

        // u0, zero wait states
        xfer(0, 1'b0, 32'h14, 64'h0, 8'h0, 1'b0, 64'h0, 1);
        xfer(0, 1'b0, 32'h14, 64'h0, 8'h0, 1'b0, 64'h0, 3);
        xfer(0, 1'b1, 32'h08, 64'h11223344, 8'hF, 1'b0, 64'h0, 1);
        xfer(0, 1'b1, 32'h08, 64'hAABBCCDD, 8'h5, 1'b0, 64'h0, 1);
        xfer(0, 1'b0, 32'h08, 64'h0, 8'h0, 1'b0, 64'h11BB33DD, 1);
        xfer(0, 1'b1, 32'h00, 64'hA5A5A5A5, 8'hF, 1'b0, 64'h0, 1);
        xfer(0, 1'b1, 32'hFF, 64'hCAFEF00D, 8'hF, 1'b0, 64'h0, 1);
        xfer(0, 1'b1, 32'h00, 64'h12345678, 8'h0, 1'b0, 64'h0, 1);
        xfer(0, 1'b0, 32'hFC, 64'h0, 8'h0, 1'b0, 64'hCAFEF00D, 1);
        xfer(0, 1'b1, 32'h100, 64'hFFFFFFFF, 8'hF, 1'b1, 64'h0, 1);
        xfer(0, 1'b1, 32'h8000_0000, 64'h77777777, 8'hF, 1'b1, 64'h0, 1);
        xfer(0, 1'b0, 32'h100, 64'h0, 8'h0, 1'b1, 64'h0, 1);
        for (int i = 0; i < 64; i++) begin
            sweep_exp = (i == 0)  ? 32'hA5A5A5A5 :
                        (i == 2)  ? 32'h11BB33DD :
                        (i == 63) ? 32'hCAFEF00D : 32'h0;
            xfer(0, 1'b0, 32'(i * 4), 64'h0, 8'h0, 1'b0, {32'h0, sweep_exp}, 1);
        end

        // u1, three wait states
        xfer(1, 1'b1, 32'h10, 64'hDEADBEEF, 8'hF, 1'b0, 64'h0, 1);
        xfer(1, 1'b0, 32'h10, 64'h0, 8'h0, 1'b0, 64'hDEADBEEF, 1);
        xfer(1, 1'b0, 32'h14, 64'h0, 8'h0, 1'b0, 64'h0, 1);

        // u3, 64-bit bus
        xfer(3, 1'b1, 32'h18, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 64'h0, 1);
        xfer(3, 1'b0, 32'h1F, 64'h0, 8'h0, 1'b0, 64'h0123456789ABCDEF, 1);
        xfer(3, 1'b1, 32'h18, 64'hFFFFFFFFFFFFFFFF, 8'hF0, 1'b0, 64'h0, 1);
        xfer(3, 1'b0, 32'h1B, 64'h0, 8'h0, 1'b0, 64'hFFFFFFFF89ABCDEF, 1);
        xfer(3, 1'b0, 32'h200, 64'h0, 8'h0, 1'b1, 64'h0, 1);

        // u2, four wait states: abort in N+2
        psel[2]  = 1'b1;
        pen[2]   = 1'b0;
        pwr[2]   = 1'b1;
        addr[2]  = 32'h04;
        wdata[2] = 64'h55555555;
        strb[2]  = 8'hF;
        @(posedge clk); #1;
        pen[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        psel[2] = 1'b0;
        pen[2]  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("u2 abort_no_ready", {63'h0, rdy2}, 64'h0);
        end
        xfer(2, 1'b0, 32'h04, 64'h0, 8'h0, 1'b0, 64'h0, 1);
        xfer(2, 1'b1, 32'h04, 64'h12345678, 8'hF, 1'b0, 64'h0, 1);
        xfer(2, 1'b0, 32'h04, 64'h0, 8'h0, 1'b0, 64'h12345678, 1);

        // u2: reset asserted while in WAIT, bus still requesting
        psel[2]  = 1'b1;
        pen[2]   = 1'b0;
        pwr[2]   = 1'b1;
        addr[2]  = 32'h04;
        wdata[2] = 64'h99999999;
        strb[2]  = 8'hF;
        @(posedge clk); #1;
        pen[2] = 1'b1;
        @(posedge clk); #1;
        rstn[2] = 1'b0;
        @(posedge clk); #1;
        chk("u2 reset_mid_wait", {rd2, 30'h0, rdy2, err2}, 64'h0);
        psel[2] = 1'b0;
        pen[2]  = 1'b0;
        @(posedge clk); #1;
        rstn[2] = 1'b1;
        xfer(2, 1'b0, 32'h04, 64'h0, 8'h0, 1'b0, 64'h0, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sbq.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
